// File: rtl/hsaf_ctrl_pkg.sv
// Shared definitions for the HSAF-LMS adaptation sequencer: state encoding
// and the default thresholds, lengths and step-size shifts.
package hsaf_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_ADAPT = 2'd2,
        ST_HOLD  = 2'd3
    } hsaf_state_t;

    localparam int          DEF_WIDTH     = 16;
    localparam int          DEF_FILL_LEN  = 20;
    localparam int          DEF_ERR_SHIFT = 4;
    localparam logic [15:0] DEF_CONV_THR  = 16'h0040;
    localparam int          DEF_CONV_CNT  = 64;
    localparam logic [15:0] DEF_DIV_THR   = 16'h0200;
    localparam int          DEF_MU_FAST   = 5;
    localparam int          DEF_MU_SLOW   = 7;
    localparam int          DEF_MU_SWITCH = 256;

endpackage

// File: rtl/hsaf_err_tracker.sv
// Error tracker: saturating |error|, leaky average of |error|, and the
// consecutive below-threshold counter. Flags are derived from the updated
// average so the sequencer can act on the same edge that samples the error.
module hsaf_err_tracker
    import hsaf_ctrl_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               ERR_SHIFT = DEF_ERR_SHIFT,
    parameter logic [WIDTH-1:0] CONV_THR  = DEF_CONV_THR,
    parameter int               CONV_CNT  = DEF_CONV_CNT,
    parameter logic [WIDTH-1:0] DIV_THR   = DEF_DIV_THR
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_stop,
    input  logic                    i_init,
    input  logic                    i_upd_adapt,
    input  logic                    i_upd_hold,
    input  logic signed [WIDTH-1:0] i_error,
    output logic [WIDTH-1:0]        o_err_avg,
    output logic                    o_conv_done,
    output logic                    o_diverged
);

    localparam int               CW       = $clog2(CONV_CNT + 1);
    localparam logic [CW-1:0]    CONV_MAX = CW'(CONV_CNT);
    localparam logic [WIDTH-1:0] ABS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]        r_err_avg;
    logic [CW-1:0]           r_conv_cnt;
    logic [WIDTH-1:0]        w_abs_e;
    logic signed [WIDTH:0]   w_diff;
    logic signed [WIDTH:0]   w_step;
    logic [WIDTH-1:0]        w_avg_new;
    logic                    w_below;
    logic                    w_above;
    logic [CW-1:0]           w_conv_inc;
    logic [CW-1:0]           w_conv_next;

    // Saturating magnitude: the most negative code has no positive twin.
    always_comb begin
        w_abs_e = i_error;
        if (i_error[WIDTH-1]) begin
            if (i_error == MOST_NEG) begin
                w_abs_e = ABS_MAX;
            end else begin
                w_abs_e = -i_error;
            end
        end
    end

    // Difference is one bit wider so it cannot wrap; the arithmetic shift
    // keeps the sign, and the sum wraps back to WIDTH bits.
    assign w_diff      = $signed({1'b0, w_abs_e}) - $signed({1'b0, r_err_avg});
    assign w_step      = w_diff >>> ERR_SHIFT;
    assign w_avg_new   = r_err_avg + w_step[WIDTH-1:0];
    assign w_below     = (w_avg_new < CONV_THR);
    assign w_above     = (w_avg_new > DIV_THR);
    assign w_conv_inc  = (r_conv_cnt == CONV_MAX) ? r_conv_cnt : r_conv_cnt + 1'b1;
    assign w_conv_next = w_below ? w_conv_inc : '0;

    assign o_err_avg   = r_err_avg;
    assign o_conv_done = i_upd_adapt && (w_conv_next == CONV_MAX);
    assign o_diverged  = i_upd_hold && w_above;

    // Average and convergence counter; stop keeps the average but drops the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_avg  <= '0;
            r_conv_cnt <= '0;
        end else if (i_stop) begin
            r_conv_cnt <= '0;
        end else if (i_init) begin
            r_err_avg  <= ABS_MAX;
            r_conv_cnt <= '0;
        end else if (i_upd_adapt) begin
            r_err_avg  <= w_avg_new;
            r_conv_cnt <= w_conv_next;
        end else if (i_upd_hold) begin
            r_err_avg  <= w_avg_new;
            if (w_above) begin
                r_conv_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/hsaf_adapt_ctrl.sv
// HSAF-LMS adaptation sequencer. Blocks adaptation while the datapath
// pipelines fill, pulses the weight-update enables per sample in ADAPT,
// freezes in HOLD once converged and re-tracks when the error grows.
// Optional build macro HSAF_ADAPT_CTRL_MU_SCHED_EN enables the fast-to-slow
// step-size schedule; without it mu_shift is fixed at MU_SLOW.
module hsaf_adapt_ctrl
    import hsaf_ctrl_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               FILL_LEN  = DEF_FILL_LEN,
    parameter int               ERR_SHIFT = DEF_ERR_SHIFT,
    parameter logic [WIDTH-1:0] CONV_THR  = DEF_CONV_THR,
    parameter int               CONV_CNT  = DEF_CONV_CNT,
    parameter logic [WIDTH-1:0] DIV_THR   = DEF_DIV_THR,
    parameter int               MU_FAST   = DEF_MU_FAST,
    parameter int               MU_SLOW   = DEF_MU_SLOW,
    parameter int               MU_SWITCH = DEF_MU_SWITCH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] error_in,
    output logic                    w_adapt_en,
    output logic                    q_adapt_en,
    output logic [2:0]              mu_shift,
    output logic [1:0]              state,
    output logic                    converged,
    output logic                    busy,
    output logic [WIDTH-1:0]        err_avg
);

    localparam int            FW        = $clog2(FILL_LEN + 1);
    localparam logic [FW-1:0] FILL_LAST = FW'(FILL_LEN - 1);

    hsaf_state_t   r_state;
    hsaf_state_t   w_state_next;
    logic [FW-1:0] r_fill_cnt;
    logic          r_adapt_en;
    logic          r_converged;
    logic          r_busy;
    logic          w_pulse_next;
    logic          w_converged_next;
    logic          w_busy_next;
    logic          w_start_ok;
    logic          w_sample;
    logic          w_fill_smp;
    logic          w_adapt_smp;
    logic          w_hold_smp;
    logic          w_fill_done;
    logic          w_conv_done;
    logic          w_diverged;

    // Qualified events; stop outranks start and data.
    assign w_start_ok  = start && !stop && (r_state == ST_IDLE);
    assign w_sample    = in_valid && !stop;
    assign w_fill_smp  = w_sample && (r_state == ST_FILL);
    assign w_adapt_smp = w_sample && (r_state == ST_ADAPT);
    assign w_hold_smp  = w_sample && (r_state == ST_HOLD);
    assign w_fill_done = w_fill_smp && (r_fill_cnt == FILL_LAST);

    hsaf_err_tracker #(
        .WIDTH     (WIDTH),
        .ERR_SHIFT (ERR_SHIFT),
        .CONV_THR  (CONV_THR),
        .CONV_CNT  (CONV_CNT),
        .DIV_THR   (DIV_THR)
    ) u_err_tracker (
        .clk         (clk),
        .reset       (reset),
        .i_stop      (stop),
        .i_init      (start && (r_state == ST_IDLE)),
        .i_upd_adapt (in_valid && (r_state == ST_ADAPT)),
        .i_upd_hold  (in_valid && (r_state == ST_HOLD)),
        .i_error     (error_in),
        .o_err_avg   (err_avg),
        .o_conv_done (w_conv_done),
        .o_diverged  (w_diverged)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        if (stop) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (start)       w_state_next = ST_FILL;
                ST_FILL:  if (w_fill_done) w_state_next = ST_ADAPT;
                ST_ADAPT: if (w_conv_done) w_state_next = ST_HOLD;
                ST_HOLD:  if (w_diverged)  w_state_next = ST_ADAPT;
                default:                   w_state_next = ST_IDLE;
            endcase
        end
    end

    // Output decode; the sample that leaves ADAPT for HOLD still pulses.
    always_comb begin
        w_pulse_next     = w_adapt_smp;
        w_converged_next = (w_state_next == ST_HOLD);
        w_busy_next      = (w_state_next != ST_IDLE);
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_adapt_en  <= 1'b0;
            r_converged <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_adapt_en  <= w_pulse_next;
            r_converged <= w_converged_next;
            r_busy      <= w_busy_next;
        end
    end

    // Pipeline fill counter.
    always_ff @(posedge clk) begin
        if (reset || stop || w_start_ok) begin
            r_fill_cnt <= '0;
        end else if (w_fill_smp) begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
        end
    end

    assign state      = r_state;
    assign w_adapt_en = r_adapt_en;
    assign q_adapt_en = r_adapt_en;
    assign converged  = r_converged;
    assign busy       = r_busy;

`ifdef HSAF_ADAPT_CTRL_MU_SCHED_EN
    localparam int            MW        = $clog2(MU_SWITCH + 1);
    localparam logic [MW-1:0] MU_MAX    = MW'(MU_SWITCH);
    localparam logic [2:0]    MU_FAST_V = 3'(MU_FAST);
    localparam logic [2:0]    MU_SLOW_V = 3'(MU_SLOW);

    logic [MW-1:0] r_mu_cnt;
    logic [2:0]    r_mu_shift;

    // Step schedule: fast for the first MU_SWITCH ADAPT samples after a fill,
    // slow from the next sample on; re-tracking out of HOLD stays slow.
    always_ff @(posedge clk) begin
        if (reset || stop) begin
            r_mu_cnt   <= '0;
            r_mu_shift <= MU_SLOW_V;
        end else if (w_start_ok) begin
            r_mu_cnt   <= '0;
        end else if (w_fill_done) begin
            r_mu_cnt   <= '0;
            r_mu_shift <= MU_FAST_V;
        end else if (w_adapt_smp) begin
            if (r_mu_cnt == MU_MAX) begin
                r_mu_shift <= MU_SLOW_V;
            end else begin
                r_mu_cnt <= r_mu_cnt + 1'b1;
            end
        end else if (w_hold_smp && w_diverged) begin
            r_mu_shift <= MU_SLOW_V;
        end
    end

    assign mu_shift = r_mu_shift;
`else
    assign mu_shift = 3'(MU_SLOW);
`endif

endmodule

// File: tb/tb_hsaf_adapt_ctrl.sv
module tb_hsaf_adapt_ctrl;

    localparam int FILL_LEN  = 20;
    localparam int ERR_SHIFT = 4;
    localparam int CONV_THR  = 64;
    localparam int CONV_CNT  = 64;
    localparam int DIV_THR   = 512;
    localparam int MU_FAST   = 5;
    localparam int MU_SLOW   = 7;
    localparam int MU_SWITCH = 256;

    typedef struct packed {
        logic [1:0]  st;
        logic        wen;
        logic        qen;
        logic        cv;
        logic        bz;
        logic [15:0] avg;
        logic [2:0]  mu;
    } exp_t;

    logic               clk;
    logic               reset;
    logic               start;
    logic               stop;
    logic               in_valid;
    logic signed [15:0] error_in;
    logic               w_adapt_en;
    logic               q_adapt_en;
    logic [2:0]         mu_shift;
    logic [1:0]         state;
    logic               converged;
    logic               busy;
    logic [15:0]        err_avg;

    hsaf_adapt_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .in_valid   (in_valid),
        .error_in   (error_in),
        .w_adapt_en (w_adapt_en),
        .q_adapt_en (q_adapt_en),
        .mu_shift   (mu_shift),
        .state      (state),
        .converged  (converged),
        .busy       (busy),
        .err_avg    (err_avg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_cycle  = 0;

    int   m_state = 0;
    int   m_fill  = 0;
    int   m_conv  = 0;
    int   m_avg   = 0;
    int   m_mucnt = 0;
    int   m_mu    = MU_SLOW;
    logic m_en    = 1'b0;

    task automatic check_cond(input logic ok, input string what);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: st=%0d w=%b q=%b cv=%b bz=%b avg=%h mu=%0d",
                     what, n_cycle, state, w_adapt_en, q_adapt_en, converged, busy,
                     err_avg, mu_shift);
        end else begin
            $display("PASS %s at cycle %0d", what, n_cycle);
        end
    endtask

    task automatic model_step(input logic rs, input logic st, input logic sp,
                              input logic v, input logic [15:0] e);
        int ei;
        int ab;
        int d;
        m_en = 1'b0;
        if (rs) begin
            m_state = 0; m_fill = 0; m_conv = 0; m_avg = 0; m_mucnt = 0; m_mu = MU_SLOW;
        end else if (sp) begin
            m_state = 0; m_fill = 0; m_conv = 0; m_mucnt = 0; m_mu = MU_SLOW;
        end else if (st && m_state == 0) begin
            m_state = 1; m_fill = 0; m_conv = 0; m_mucnt = 0; m_avg = 32767;
        end else if (v) begin
            ei = int'($signed(e));
            ab = (ei < 0) ? -ei : ei;
            if (ab > 32767) ab = 32767;
            d = ab - m_avg;
            d = d >>> ERR_SHIFT;
            case (m_state)
                1: begin
                    m_fill++;
                    if (m_fill == FILL_LEN) begin
                        m_state = 2; m_mu = MU_FAST; m_mucnt = 0;
                    end
                end
                2: begin
                    m_en  = 1'b1;
                    m_avg = m_avg + d;
                    m_conv = (m_avg < CONV_THR) ? m_conv + 1 : 0;
                    if (m_mucnt >= MU_SWITCH) m_mu = MU_SLOW;
                    else m_mucnt++;
                    if (m_conv >= CONV_CNT) m_state = 3;
                end
                3: begin
                    m_avg = m_avg + d;
                    if (m_avg > DIV_THR) begin
                        m_state = 2; m_conv = 0; m_mu = MU_SLOW;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic cycle(input logic rs, input logic st, input logic sp,
                         input logic v, input logic [15:0] e);
        exp_t x;
        reset    = rs;
        start    = st;
        stop     = sp;
        in_valid = v;
        error_in = e;
        model_step(rs, st, sp, v, e);
        x.st  = 2'(m_state);
        x.wen = m_en;
        x.qen = m_en;
        x.cv  = (m_state == 3);
        x.bz  = (m_state != 0);
        x.avg = 16'(m_avg);
`ifdef HSAF_ADAPT_CTRL_MU_SCHED_EN
        x.mu  = 3'(m_mu);
`else
        x.mu  = 3'(MU_SLOW);
`endif
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    function automatic logic [15:0] rnd_err();
        int r;
        int s;
        r = $urandom_range(0, 9);
        if (r == 0) return 16'h8000;
        if (r <= 2) return 16'h0000;
        if (r <= 5) begin
            s = $urandom_range(0, 255) - 128;
            return 16'(s);
        end
        return 16'($urandom);
    endfunction

    exp_t mon_exp;
    exp_t mon_got;
    always @(posedge clk) begin
        #1;
        n_cycle++;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {state, w_adapt_en, q_adapt_en, converged, busy, err_avg, mu_shift};
            n_checks++;
            if (mon_got !== mon_exp) begin
                n_fail++;
                $display("FAIL outputs cycle %0d: got st=%0d w=%b q=%b cv=%b bz=%b avg=%h mu=%0d, want st=%0d w=%b q=%b cv=%b bz=%b avg=%h mu=%0d",
                         n_cycle, mon_got.st, mon_got.wen, mon_got.qen, mon_got.cv, mon_got.bz,
                         mon_got.avg, mon_got.mu, mon_exp.st, mon_exp.wen, mon_exp.qen,
                         mon_exp.cv, mon_exp.bz, mon_exp.avg, mon_exp.mu);
            end
        end
    end

    initial begin
        int s;
        reset = 1'b1; start = 1'b1; stop = 1'b0; in_valid = 1'b0; error_in = '0;

        cycle(1, 1, 0, 0, 16'h0);
        cycle(1, 1, 0, 0, 16'h0);
        check_cond((state == 2'd0) && (w_adapt_en == 1'b0) && (q_adapt_en == 1'b0) &&
                   (converged == 1'b0) && (busy == 1'b0) && (err_avg == 16'h0000) &&
                   (mu_shift == 3'(MU_SLOW)), "reset state");
        repeat (3) cycle(0, 0, 0, 1'($urandom_range(0, 1)), 16'($urandom));

        cycle(0, 1, 0, 0, 16'h0);
        repeat (FILL_LEN) cycle(0, 0, 0, 1, 16'($urandom));

        for (int i = 0; i < 320; i++) begin
            s = $urandom_range(0, 8192) - 4096;
            cycle(0, (i == 50), 0, ($urandom_range(0, 7) != 0),
                  (i % 37 == 0) ? 16'h8000 : 16'(s));
        end

        for (int n = 0; n < 3000 && m_state != 3; n++) cycle(0, 0, 0, 1, 16'h0);
        check_cond((m_state == 3) && (state == 2'd3) && (converged == 1'b1),
                   "convergence wait");
        repeat (5) cycle(0, 0, 0, 1, 16'h0);

        for (int n = 0; n < 500 && m_state != 2; n++) cycle(0, 0, 0, 1, 16'h1000);
        check_cond((m_state == 2) && (state == 2'd2) && (converged == 1'b0),
                   "re-track wait");
        repeat (3) cycle(0, 0, 0, 1, 16'h8000);

        cycle(0, 0, 1, 1, 16'h1000);
        cycle(0, 0, 0, 1, 16'h0);

        cycle(0, 1, 0, 0, 16'h0);
        repeat (10) cycle(0, 0, 0, 1, 16'h0100);
        cycle(0, 0, 1, 0, 16'h0);
        cycle(0, 1, 1, 0, 16'h0);
        cycle(0, 0, 0, 1, 16'h0);
        cycle(0, 1, 0, 0, 16'h0);
        for (int i = 0; i < 40; i++) cycle(0, (i == 7), 0, 1'($urandom_range(0, 1)), rnd_err());

        for (int i = 0; i < 1500; i++) begin
            cycle((i == 700), ($urandom_range(0, 99) < 3), ($urandom_range(0, 199) < 1),
                  ($urandom_range(0, 99) < 75), rnd_err());
        end
        cycle(0, 0, 0, 0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hsaf_adapt_ctrl.md
# hsaf_adapt_ctrl

Adaptation sequencer for the HSAF-LMS log-domain filter. It watches the per-sample error and produces registered update-enable strobes for the linear weight bank (`w_adapt_en`) and the spline q-weight bank (`q_adapt_en`). It blocks adaptation until the tap and spline pipelines have filled after a start. It tracks a leaky average of |error| and freezes adaptation once the filter has converged. If the error grows again after convergence, it resumes adaptation.

## Interface

**Parameters**
- `WIDTH`, 16: error and average width, two's complement.
- `FILL_LEN`, 20: samples needed to flush the datapath pipelines (L_ORD + RET).
- `ERR_SHIFT`, 4: leak factor of the error average, 2^-ERR_SHIFT.
- `CONV_THR`, 16'h0040: convergence threshold on `err_avg`.
- `CONV_CNT`, 64: number of consecutive below-threshold samples that declares convergence.
- `DIV_THR`, 16'h0200: re-track threshold used in HOLD.
- `MU_FAST`, 5: fast step-size shift.
- `MU_SLOW`, 7: slow step-size shift.
- `MU_SWITCH`, 256: ADAPT samples before stepping from fast to slow.

**Ports**
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: single-cycle pulse; begins a run.
- `stop`, in, 1: single-cycle pulse; aborts the run and returns to IDLE.
- `in_valid`, in, 1: new-sample strobe, aligned with `error_in`.
- `error_in`, in, WIDTH: signed error for the current sample.
- `w_adapt_en`, out, 1: linear weight update enable.
- `q_adapt_en`, out, 1: spline weight update enable.
- `mu_shift`, out, 3: step-size right-shift applied to the error.
- `state`, out, 2: current FSM state.
- `converged`, out, 1: high while in HOLD.
- `busy`, out, 1: high whenever state is not IDLE.
- `err_avg`, out, WIDTH: unsigned leaky average of |error|.

## Operation

**States:** IDLE=0, FILL=1, ADAPT=2, HOLD=3. Priority order is reset > stop > start > data events.

**IDLE**
- All enables are 0.
- `start` moves to FILL.
- On `start`: `fill_cnt`, `conv_cnt` and `mu_cnt` clear to 0, and `err_avg` loads 16'h7FFF so convergence cannot be declared falsely.
- `start` together with `stop` leaves the FSM in IDLE.

**FILL**
- Each `in_valid` increments `fill_cnt`.
- The `in_valid` with `fill_cnt == FILL_LEN-1` moves the FSM to ADAPT.
- `err_avg` is not updated in FILL.

**ADAPT**
- Each `in_valid` produces `w_adapt_en` and `q_adapt_en` pulses.
- `err_avg` updates on each `in_valid`.
- `conv_cnt` increments when the updated `err_avg < CONV_THR`; otherwise it clears to 0.
- When `conv_cnt` reaches CONV_CNT, the FSM moves to HOLD.

**HOLD**
- Enables are 0 and `err_avg` keeps updating.
- When the updated `err_avg > DIV_THR`, the FSM moves to ADAPT and `conv_cnt` clears.

**Error average arithmetic**
- `abs_e = |error_in|`, saturating, so 16'h8000 maps to 16'h7FFF.
- `err_avg += (abs_e - err_avg) >>> ERR_SHIFT`. The difference is computed signed at WIDTH+1 bits with an arithmetic shift, and the result is truncated to WIDTH.

**Other rules**
- `start` outside IDLE is ignored.
- `stop` in any state returns to IDLE and clears all counters. `err_avg` holds its value.

## Timing

- All outputs are registered.
- Reset values: `state`=IDLE, all enables 0, `converged`=0, `busy`=0, `err_avg`=0, `mu_shift`=MU_SLOW.
- State and `err_avg` change on the clock edge that samples the qualifying `in_valid` or `start`. The outputs show the new values from the next cycle.
- `w_adapt_en` and `q_adapt_en` are one-cycle pulses with latency 1 from an `in_valid` sampled while `state==ADAPT` and `stop==0`. The transition sample into HOLD still produces its pulse.
- The `in_valid` that completes FILL does not pulse. The first pulse follows the (FILL_LEN+1)-th sample.
- `stop` together with `in_valid` in ADAPT gives no pulse.
- `in_valid` may be high every cycle. No backpressure is applied.

## Configuration

- **`HSAF_ADAPT_CTRL_MU_SCHED_EN` defined:** on each ADAPT entry from FILL, `mu_shift` is MU_FAST. `mu_cnt` counts ADAPT samples (saturating), and `mu_shift` becomes MU_SLOW after MU_SWITCH samples. A HOLD-to-ADAPT re-track keeps MU_SLOW.
- **Undefined:** `mu_shift` is constantly MU_SLOW and `mu_cnt` is not built.

## Structure

- **Package `hsaf_ctrl_pkg`:** the state encoding (IDLE/FILL/ADAPT/HOLD as a 2-bit typedef) and the default thresholds and shifts.
- **Sub-module `hsaf_err_tracker`:** saturating abs, leaky average, `conv_cnt`, and the below-threshold / above-threshold flags. The FSM, fill counter and mu schedule stay in the top-level module.

## Test plan

1. **Reset:** assert `reset` for 2 cycles with `start` high → `state`=0, enables 0, `err_avg`=0, `mu_shift`=7. `start` is ignored during reset.
2. **Fill:** `start`, then 20 consecutive `in_valid` → `state`=2 the cycle after the 20th. The first `w_adapt_en` appears after the 21st sample; exactly one pulse per sample thereafter.
3. **Convergence:** `error_in`=0 continuously → `err_avg` decays monotonically from 16'h7FFF. `converged` rises exactly 64 samples after the first sample with `err_avg` < 16'h0040, and the enables stop.
4. **Re-track:** in HOLD, `error_in`=16'h1000 → `state` returns to 2 on the first sample with `err_avg` > 16'h0200; `converged` falls.
5. **Saturation and abort:** `error_in`=16'h8000 in ADAPT → abs is treated as 16'h7FFF. `stop` at `fill_cnt`=10 → IDLE the next cycle, and the following `start` requires the full 20 samples. `start` and `stop` in the same cycle in IDLE → stays in IDLE.
6. **Mu schedule (macro defined):** `mu_shift`=5 for the first 256 ADAPT samples, then 7. Macro undefined: `mu_shift`=7 throughout.
